// File: rtl/sdram_bist.sv
// Built-in self-test engine for the SDRAM controller port: a full write pass
// followed by a read-verify pass over [0, last_addr] with one of four data patterns.
module sdram_bist #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 26,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h9C,
  parameter logic [DATA_WIDTH-1:0] SEED       = 8'h9C,
  parameter logic [DATA_WIDTH-1:0] POLY       = 8'hB8,
  parameter int                    TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic                  mem_busy,
  input  logic                  mem_data_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, last_q;
  logic [DATA_WIDTH-1:0]  lfsr_q, lfsr_next, exp_data, rd_data_q;
  logic [1:0]             mode_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rd_to_q;
  logic [15:0]            err_q;
  logic                   fail_q, timeout_q;
  logic [ADDR_WIDTH-1:0]  fail_addr_q;
  logic [DATA_WIDTH-1:0]  fail_exp_q, fail_act_q;

  logic addr_last, wr_exit, rd_expired, is_error;

  assign addr_last  = (addr_q == last_q);
  // cnt_q is nonzero once the post-pulse latency cycle has been skipped
  assign wr_exit    = (cnt_q != '0) && !mem_busy;
  assign rd_expired = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign is_error   = rd_to_q || (rd_data_q != exp_data);
  assign lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    exp_data = PATTERN;
    case (mode_q)
      2'd0: exp_data = PATTERN;
      2'd1: exp_data = DATA_WIDTH'(addr_q);
      2'd2: exp_data = lfsr_q;
      2'd3: exp_data = DATA_WIDTH'(1) << (addr_q % ADDR_WIDTH'(DATA_WIDTH));
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)     state_d = S_WR_REQ;
      S_WR_REQ:       if (!mem_busy) state_d = S_WR_WAIT;
      S_WR_WAIT:      if (wr_exit)   state_d = addr_last ? S_RD_REQ : S_WR_REQ;
      S_RD_REQ:       if (!mem_busy) state_d = S_RD_WAIT;
      S_RD_WAIT:      if (mem_data_ready || rd_expired) state_d = S_CHECK;
      S_CHECK:        state_d = addr_last ? S_DONE : S_RD_REQ;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_wr  = (state_q == S_WR_REQ) && !mem_busy;
    mem_rd  = (state_q == S_RD_REQ) && !mem_busy;
    busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    done    = (state_q == S_DONE);
    pass    = done && (err_q == '0);
    mem_din = '0;
    if (state_q == S_WR_REQ || state_q == S_WR_WAIT) mem_din = exp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q      <= '0;
      last_q      <= '0;
      lfsr_q      <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      rd_data_q   <= '0;
      rd_to_q     <= 1'b0;
      err_q       <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q      <= mode;
            last_q      <= last_addr;
            addr_q      <= '0;
            lfsr_q      <= SEED;
            err_q       <= '0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
          end
        end
        S_WR_REQ, S_RD_REQ: cnt_q <= '0;
        S_WR_WAIT: begin
          cnt_q <= CNT_W'(1);
          if (wr_exit) begin
            if (addr_last) begin
              // Read pass replays the same LFSR sequence from the seed
              addr_q <= '0;
              lfsr_q <= SEED;
            end else begin
              addr_q <= addr_q + 1'b1;
              lfsr_q <= lfsr_next;
            end
          end
        end
        S_RD_WAIT: begin
          if (mem_data_ready) begin
            rd_data_q <= mem_dout;
            rd_to_q   <= 1'b0;
          end else if (rd_expired) begin
            rd_data_q <= '0;
            rd_to_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (is_error) begin
            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            fail_q <= 1'b1;
            if (!fail_q) begin
              fail_addr_q <= addr_q;
              fail_exp_q  <= exp_data;
              fail_act_q  <= rd_data_q;
            end
          end
          if (!addr_last) begin
            addr_q <= addr_q + 1'b1;
            lfsr_q <= lfsr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr      = addr_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign err_count     = err_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_exp_q;
  assign fail_actual   = fail_act_q;

endmodule
